detector_stream_arbiter: RTL

Round-robin arbiter and serializer that shares one single-bit sequence-detector FSM among NREQ requesters. The detector may be Moore or Mealy style, selected by a parameter. For each granted job it clears the detector, shifts the requester's word MSB-first onto the detector's serial input, and counts detector hits. It then returns the count to the requester with a one-cycle done pulse. It sits between client blocks and a detector instance with ports clk, w, Resetn, z.

---
 rtl/detector_stream_arbiter.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/detector_stream_arbiter.sv
// Round-robin arbiter that time-shares one serial sequence detector among NREQ clients.
// Each granted word is shifted MSB-first into a freshly cleared detector and its hits are counted.
module detector_stream_arbiter #(
    parameter int NREQ   = 4,
    parameter int DATA_W = 8,
    parameter int CNT_W  = 4,
    parameter int MOORE  = 1
) (
    input  logic                   clk,
    input  logic                   Resetn,
    input  logic [NREQ-1:0]        req,
    input  logic [NREQ*DATA_W-1:0] req_data,
    output logic [NREQ-1:0]        gnt,
    output logic                   busy,
    output logic                   done,
    output logic [2:0]             done_id,
    output logic [CNT_W-1:0]       hit_count,
    output logic                   det_w,
    output logic                   det_resetn,
    input  logic                   det_z,
    output logic [2:0]             state_dbg
);

    localparam int PTR_W = $clog2(NREQ);
    localparam int BIT_W = $clog2(DATA_W);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLR   = 3'd1,
        S_SHIFT = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t             state, state_nxt;
    logic [PTR_W-1:0]   ptr, winner, pick;
    logic               found;
    logic [DATA_W-1:0]  shreg;
    logic [BIT_W-1:0]   bitcnt;
    logic [CNT_W-1:0]   acc, acc_nxt;
    logic               sample_en, last_bit;

    // Handshake: req is a level held by the client until its done pulse; gnt marks the
    // job owner from grant edge to DONE exit; done is a one-cycle strobe with done_id/hit_count.

    function automatic logic [PTR_W-1:0] rr_index(input logic [PTR_W-1:0] base, input int k);
        int s;
        s = int'(base) + k;
        if (s >= NREQ) s = s - NREQ;
        return PTR_W'(s);
    endfunction

    always_comb begin
        pick  = '0;
        found = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            if (!found && req[rr_index(ptr, k)]) begin
                found = 1'b1;
                pick  = rr_index(ptr, k);
            end
        end
    end

    always_ff @(posedge clk or negedge Resetn) begin
        if (!Resetn) state <= S_IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        busy       = (state != S_IDLE);
        det_w      = 1'b0;
        det_resetn = Resetn & (state != S_CLR);
        last_bit   = (bitcnt == BIT_W'(DATA_W - 1));
        // A Moore detector's z lags w by one cycle, so its first SHIFT cycle still shows
        // the cleared state and the final bit is picked up in DRAIN instead.
        sample_en  = ((state == S_SHIFT) && ((MOORE == 0) || (bitcnt != '0)))
                     || (state == S_DRAIN);
        acc_nxt    = acc + CNT_W'(sample_en & det_z);
        state_dbg  = state;
        case (state)
            S_IDLE:  if (found) state_nxt = S_CLR;
            S_CLR:   state_nxt = S_SHIFT;
            S_SHIFT: begin
                det_w = shreg[DATA_W-1];
                if (last_bit) state_nxt = (MOORE != 0) ? S_DRAIN : S_DONE;
            end
            S_DRAIN: state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge Resetn) begin
        if (!Resetn) begin
            gnt       <= '0;
            winner    <= '0;
            ptr       <= '0;
            shreg     <= '0;
            bitcnt    <= '0;
            acc       <= '0;
            done      <= 1'b0;
            done_id   <= '0;
            hit_count <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (found) begin
                        gnt    <= NREQ'(1) << pick;
                        winner <= pick;
                        shreg  <= req_data[pick*DATA_W +: DATA_W];
                        acc    <= '0;
                    end
                end
                S_CLR: bitcnt <= '0;
                S_SHIFT: begin
                    shreg  <= shreg << 1;
                    bitcnt <= bitcnt + BIT_W'(1);
                    acc    <= acc_nxt;
                    if (last_bit && (MOORE == 0)) begin
                        done      <= 1'b1;
                        done_id   <= 3'(winner);
                        hit_count <= acc_nxt;
                    end
                end
                S_DRAIN: begin
                    acc       <= acc_nxt;
                    done      <= 1'b1;
                    done_id   <= 3'(winner);
                    hit_count <= acc_nxt;
                end
                S_DONE: begin
                    done <= 1'b0;
                    gnt  <= '0;
                    ptr  <= (winner == PTR_W'(NREQ - 1)) ? '0 : winner + PTR_W'(1);
                end
                default: ;
            endcase
        end
    end

endmodule
